// File: rtl/class_score_accumulator.sv
// class_score_accumulator
//   Sweeps every grid cell once per start pulse, reading one class weight ROM
//   and the activity grid (both 1-cycle latency), and accumulates the signed
//   dot product sum(weight * activity). The result is presented on score with
//   a one-cycle score_valid pulse.
//
//   Optional build macro SCORE_SAT_EN: when defined the accumulator saturates
//   on overflow; otherwise it wraps modulo 2^ACC_BITS. overflow is flagged
//   (sticky for the sweep) in both builds.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   start        begin a sweep (sampled only in IDLE)
//   cell_addr    address to weight ROM and activity memory
//   rd_en        high while a valid address is presented
//   weight_din   signed ROM data, valid 1 cycle after address
//   feat_din     unsigned activity count, valid 1 cycle after address
//   busy         sweep (including drain) in progress
//   score        final dot product, held until the next sweep completes
//   score_valid  one-cycle pulse when score updates
//   overflow     accumulator left its range during the last sweep
`timescale 1ns/1ps
module class_score_accumulator #(
  parameter int NUM_CELLS   = 1024,
  parameter int WEIGHT_BITS = 8,
  parameter int FEAT_BITS   = 4,
  parameter int ACC_BITS    = 24
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  output logic [$clog2(NUM_CELLS)-1:0]    cell_addr,
  output logic                            rd_en,
  input  logic signed [WEIGHT_BITS-1:0]   weight_din,
  input  logic [FEAT_BITS-1:0]            feat_din,
  output logic                            busy,
  output logic signed [ACC_BITS-1:0]      score,
  output logic                            score_valid,
  output logic                            overflow
);

  localparam int AW = $clog2(NUM_CELLS);
  localparam int PW = WEIGHT_BITS + FEAT_BITS + 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_CELLS - 1);

  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_t;

  state_t                     state, state_nxt;
  logic                       drain_cnt;
  logic                       rd_q;
  logic signed [ACC_BITS-1:0] acc, acc_nxt;
  logic signed [PW-1:0]       product;
  logic signed [ACC_BITS:0]   sum;
  logic                       ovf_step;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SWEEP;
      SWEEP:   if (cell_addr == LAST_ADDR) state_nxt = DRAIN;
      DRAIN:   if (drain_cnt) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign rd_en = (state == SWEEP);
  assign busy  = (state == SWEEP) || (state == DRAIN);

  // Activity is zero-extended so the multiply stays signed and non-negative
  // on that side; the sum is formed one bit wider to expose overflow.
  always_comb begin
    product  = $signed(weight_din) * $signed({1'b0, feat_din});
    sum      = {acc[ACC_BITS-1], acc} + {{(ACC_BITS + 1 - PW){product[PW-1]}}, product};
    ovf_step = sum[ACC_BITS] != sum[ACC_BITS-1];
`ifdef SCORE_SAT_EN
    if (ovf_step)
      acc_nxt = sum[ACC_BITS] ? {1'b1, {(ACC_BITS-1){1'b0}}} : {1'b0, {(ACC_BITS-1){1'b1}}};
    else
      acc_nxt = sum[ACC_BITS-1:0];
`else
    acc_nxt = sum[ACC_BITS-1:0];
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cell_addr   <= '0;
      drain_cnt   <= 1'b0;
      rd_q        <= 1'b0;
      acc         <= '0;
      score       <= '0;
      score_valid <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      state       <= state_nxt;
      rd_q        <= rd_en;
      score_valid <= 1'b0;

      // rd_q marks the cycle in which the memories return data for the
      // address presented one cycle earlier.
      if (rd_q) begin
        acc <= acc_nxt;
        if (ovf_step) overflow <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (start) begin
            acc       <= '0;
            overflow  <= 1'b0;
            cell_addr <= '0;
            drain_cnt <= 1'b0;
          end
        end
        SWEEP: begin
          cell_addr <= (cell_addr == LAST_ADDR) ? '0 : cell_addr + 1'b1;
        end
        DRAIN: begin
          drain_cnt <= ~drain_cnt;
          // Final accumulation landed at the end of the first drain cycle.
          if (drain_cnt) begin
            score       <= acc;
            score_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_class_score_accumulator.sv
`timescale 1ns/1ps
module tb_class_score_accumulator;

  localparam int N   = 1024;
  localparam int WB  = 8;
  localparam int FB  = 4;
  localparam int ABA = 24;
  localparam int ABB = 13;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  always #5 clk = ~clk;

  logic [9:0] addr_a, addr_b;
  logic rd_a, rd_b, busy_a, busy_b, sv_a, sv_b, ov_a, ov_b;
  logic signed [ABA-1:0] score_a;
  logic signed [ABB-1:0] score_b;
  logic signed [WB-1:0] w_a = '0, w_b = '0;
  logic [FB-1:0] f_a = '0, f_b = '0;

  logic signed [WB-1:0] wmem [N];
  logic [FB-1:0]        fmem [N];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read memories, one read port per instance.
  always @(posedge clk) begin
    if (rd_a) begin w_a <= wmem[addr_a]; f_a <= fmem[addr_a]; end
    if (rd_b) begin w_b <= wmem[addr_b]; f_b <= fmem[addr_b]; end
  end

  class_score_accumulator #(.NUM_CELLS(N), .WEIGHT_BITS(WB), .FEAT_BITS(FB), .ACC_BITS(ABA)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .cell_addr(addr_a), .rd_en(rd_a),
    .weight_din(w_a), .feat_din(f_a), .busy(busy_a), .score(score_a),
    .score_valid(sv_a), .overflow(ov_a));

  class_score_accumulator #(.NUM_CELLS(N), .WEIGHT_BITS(WB), .FEAT_BITS(FB), .ACC_BITS(ABB)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .cell_addr(addr_b), .rd_en(rd_b),
    .weight_din(w_b), .feat_din(f_b), .busy(busy_b), .score(score_b),
    .score_valid(sv_b), .overflow(ov_b));

  typedef struct {
    longint score;
    bit     ovf;
    int     cyc;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input longint act, input longint req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Dot product over the whole grid with the accumulator's range rules
  // applied step by step.
  function automatic exp_t model(input int bits, input int s);
    exp_t   e;
    longint lo, hi, m, acc, t;
    bit     ovf;
    m   = longint'(1) <<< bits;
    lo  = -(m / 2);
    hi  = (m / 2) - 1;
    acc = 0;
    ovf = 0;
    for (int i = 0; i < N; i++) begin
      t = acc + longint'(wmem[i]) * longint'(fmem[i]);
      if (t > hi || t < lo) begin
        ovf = 1;
`ifdef SCORE_SAT_EN
        acc = (t > hi) ? hi : lo;
`else
        acc = ((t % m) + m) % m;
        if (acc > hi) acc = acc - m;
`endif
      end else begin
        acc = t;
      end
    end
    e.score = acc;
    e.ovf   = ovf;
    e.cyc   = s + N + 3;
    return e;
  endfunction

  task automatic push(input int s);
    qa.push_back(model(ABA, s));
    qb.push_back(model(ABB, s));
  endtask

  // Monitor: scoreboard pops, score hold, address sequence.
  longint held_a = 0, held_b = 0;
  int     addr_cnt = 0;
  bit     prev_rd = 0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      held_a   = 0;
      held_b   = 0;
      addr_cnt = 0;
      prev_rd  = 0;
    end else begin
      if (rd_a) begin
        check("cell_addr", longint'(addr_a), longint'(addr_cnt));
        addr_cnt++;
      end else if (prev_rd) begin
        check("sweep_len", longint'(addr_cnt), longint'(N));
        addr_cnt = 0;
      end
      prev_rd = rd_a;

      if (sv_a) begin
        if (qa.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL valid_a: unexpected score_valid, score %0d (t=%0t)", score_a, $time);
        end else begin
          e = qa.pop_front();
          check("score_a", longint'(score_a), e.score);
          check("overflow_a", longint'(ov_a), longint'(e.ovf));
          check("valid_cycle_a", longint'(cyc), longint'(e.cyc));
          held_a = e.score;
        end
      end else begin
        check("score_hold_a", longint'(score_a), held_a);
      end

      if (sv_b) begin
        if (qb.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL valid_b: unexpected score_valid, score %0d (t=%0t)", score_b, $time);
        end else begin
          e = qb.pop_front();
          check("score_b", longint'(score_b), e.score);
          check("overflow_b", longint'(ov_b), longint'(e.ovf));
          check("valid_cycle_b", longint'(cyc), longint'(e.cyc));
          held_b = e.score;
        end
      end else begin
        check("score_hold_b", longint'(score_b), held_b);
      end
    end
  end

  task automatic load(input int kind);
    int row;
    for (int i = 0; i < N; i++) begin
      row = i / 32;
      case (kind)
        0: begin wmem[i] = 8'sd6; fmem[i] = 4'd1; end
        1, 2: begin
          wmem[i] = (row < 16) ? 8'((16 - row) * 6) : 8'(-((row - 15) * 4));
          if (kind == 1) fmem[i] = (row < 16) ? 4'd15 : 4'd0;
          else           fmem[i] = (row < 16) ? 4'd0 : 4'd15;
        end
        4: begin wmem[i] = 8'sd127; fmem[i] = 4'd15; end
        5: begin wmem[i] = -8'sd128; fmem[i] = 4'd15; end
        default: begin wmem[i] = 8'($urandom); fmem[i] = 4'($urandom); end
      endcase
    end
  endtask

  task automatic wait_done();
    int i;
    i = 0;
    while ((qa.size() != 0 || qb.size() != 0) && i < 2 * N + 200) begin
      @(negedge clk);
      i++;
    end
    if (qa.size() != 0 || qb.size() != 0) begin
      n_cmp++; n_fail++;
      $display("FAIL timeout: %0d/%0d results outstanding, required 0", qa.size(), qb.size());
      qa.delete();
      qb.delete();
    end
    @(negedge clk);
    check("busy_idle", longint'(busy_a), 0);
  endtask

  task automatic sweep(input bit poke);
    int s;
    @(negedge clk);
    s = cyc;
    push(s);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_sweep", longint'(busy_a), 1);
    check("rd_en_sweep", longint'(rd_a), 1);
    if (poke) begin
      repeat (9) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_done();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    #3;
    check("rst_addr", longint'(addr_a), 0);
    check("rst_rd_en", longint'(rd_a), 0);
    check("rst_busy", longint'(busy_a), 0);
    check("rst_score", longint'(score_a), 0);
    check("rst_valid", longint'(sv_a), 0);
    check("rst_overflow", longint'(ov_a), 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;

    load(0); sweep(1'b0);
    load(1); sweep(1'b0);
    load(2); sweep(1'b0);
    load(3); sweep(1'b1);

    // Abort a sweep with reset partway through.
    load(3);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (499) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_addr", longint'(addr_a), 0);
    check("abort_rd_en", longint'(rd_a), 0);
    check("abort_busy", longint'(busy_a), 0);
    check("abort_score_a", longint'(score_a), 0);
    check("abort_score_b", longint'(score_b), 0);
    check("abort_valid", longint'(sv_a), 0);
    check("abort_overflow", longint'(ov_a), 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (N + 50) @(negedge clk);
    check("abort_idle", longint'(busy_a), 0);
    sweep(1'b0);

    load(4); sweep(1'b0);
    load(5); sweep(1'b0);

    // start held high: two sweeps separated by one IDLE cycle.
    begin
      int s;
      @(negedge clk);
      s = cyc;
      push(s);
      push(s + N + 4);
      start = 1'b1;
      repeat (N + 5) @(negedge clk);
      check("b2b_busy", longint'(busy_a), 1);
      start = 1'b0;
      wait_done();
    end

    load(3); sweep(1'b0);

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/class_score_accumulator.md
Name: class_score_accumulator

Overview:
- Reader side of the per-class weight ROM read interface.
- On a start pulse it sweeps every grid cell address once and issues synchronous reads to one class weight ROM and to the event-activity grid memory.
- Both memories have 1-cycle read latency. The block forms the signed dot product sum(weight × activity) and presents the class score with a one-cycle valid pulse.
- Four instances, one per class, sit between the activity grid and the argmax/classifier stage.

Parameters:
- NUM_CELLS, 1024, grid cells per sweep (GRID_SIZE²); must be ≥ 2.
- WEIGHT_BITS, 8, signed weight width from ROM.
- FEAT_BITS, 4, unsigned per-cell activity count width.
- ACC_BITS, 24, signed accumulator/score width; must be ≥ WEIGHT_BITS+FEAT_BITS+1.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a sweep; sampled only in IDLE
- cell_addr  out  $clog2(NUM_CELLS)  address to weight ROM and activity memory
- rd_en  out  1  high in the cycle a valid address is presented
- weight_din  in  WEIGHT_BITS signed  ROM data, valid 1 cycle after address
- feat_din  in  FEAT_BITS unsigned  activity data, valid 1 cycle after address
- busy  out  1  sweep in progress
- score  out  ACC_BITS signed  final dot product, held until next sweep completes
- score_valid  out  1  one-cycle pulse when score updates
- overflow  out  1  accumulator exceeded range during last sweep (sticky per sweep)

Behaviour:
- Reset (async, rst_n=0): state=IDLE, cell_addr=0, rd_en=0, busy=0, score=0, score_valid=0, overflow=0, accumulator=0, read-valid pipeline bits=0. Deasserting reset mid-sweep leaves the block in IDLE with no score_valid pulse.
- States: IDLE, SWEEP, DRAIN, DONE.
- IDLE: start=1 → clear accumulator and overflow flag, cell_addr=0, go to SWEEP. start=0 → stay.
- SWEEP: rd_en=1, busy=1. cell_addr increments by 1 each cycle. In the cycle cell_addr=NUM_CELLS-1, go to DRAIN; cell_addr returns to 0 with no wrap beyond.
- DRAIN: rd_en=0, busy=1. Lasts two cycles so the final ROM output and its accumulation complete. Then go to DONE.
- DONE: latch score=accumulator, pulse score_valid for 1 cycle, busy=0, return to IDLE.
- Timing: start sampled at edge of cycle 0 → address k presented in cycle k+1 → data registered by the ROM valid in cycle k+2 → accumulator updated at end of cycle k+2. score_valid is high exactly in cycle NUM_CELLS+3, i.e. cycle 1027 for the default.
- A delayed copy of rd_en qualifies accumulation. The accumulator never adds when the qualifier is low.
- Arithmetic: product = weight_din (signed) × {1'b0, feat_din} (signed, non-negative). Sign-extend the product to ACC_BITS+1 and add. Overflow is detected when the (ACC_BITS+1)-bit sum differs from its ACC_BITS truncation sign-extended.
- start while busy, or in the DONE cycle: ignored, not queued.
- start held high continuously: a new sweep begins the cycle after DONE, so back-to-back sweeps run with one IDLE cycle between them.
- score holds its previous value throughout a sweep.

Optional Feature:
- Macro SCORE_SAT_EN.
- Defined: on overflow the accumulator clamps to +(2^(ACC_BITS-1)-1) or -2^(ACC_BITS-1) and stays clamped in that direction until a subsequent add moves it back in range. overflow is set.
- Undefined: the accumulator wraps modulo 2^ACC_BITS. overflow is still set on any wrap event, for observability.

Test Plan:
- Weights all +6, feats all 1, NUM_CELLS=1024 → score=6144, score_valid exactly 1027 cycles after start, overflow=0.
- UP-class pattern (rows 0–15 = (16-row)×6, rows 16–31 = -(row-15)×4), feats=15 in rows 0–15 only → score=15×32×816=391680; same feats with feats in rows 16–31 only → score=-15×32×544=-261120.
- start pulsed again 10 cycles into a sweep → no effect; exactly one score_valid; cell_addr sequence strictly 0..1023.
- rst_n asserted at cycle 500 of a sweep → all outputs 0 immediately (async); no score_valid; the next start produces a correct full sweep.
- ACC_BITS=13, weights +127, feats 15 → with SCORE_SAT_EN, score=4095 and overflow=1; without it, score equals the modulo-8192 wrapped value and overflow=1.
- Weights -128, feats 15, all cells (default widths) → score=-1966080, overflow=0; then start held high → consecutive score_valid pulses 1028 cycles apart.
